// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: response codes, the burst-master state encoding and
// the helper that gives the widest legal beat size for a data bus.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } master_state_e;

  function automatic logic [2:0] max_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// AXI4 single-burst initiator: one INCR read or write burst per client command,
// no IDs, no AW/W overlap. Optional 4 KB crossing guard: AXI4_BOUNDARY_CHECK_EN.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  done_proto_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY
);

  master_state_e         state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            resp_q;
  logic                  perr_q;
  logic                  last_beat;
  logic                  cross_4k;
  logic                  reject;
  logic                  w_hs;
  logic                  r_hs;

`ifdef AXI4_BOUNDARY_CHECK_EN
  // Extra 9 bits hold the full (len+1)<<size span so the end address never wraps.
  localparam int EW = ADDR_WIDTH + 9;
  logic [EW-1:0] end_addr;
  assign end_addr = EW'(cmd_addr) + ((EW'(cmd_len) + EW'(1)) << cmd_size) - EW'(1);
  assign cross_4k = ((end_addr >> 12) != (EW'(cmd_addr) >> 12));
`else
  assign cross_4k = 1'b0;
`endif

  assign reject    = (cmd_size > max_size(DATA_WIDTH)) || cross_4k;
  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = WVALID && WREADY;
  assign r_hs      = RVALID && RREADY;

  assign AWADDR         = addr_q;
  assign AWLEN          = len_q;
  assign AWSIZE         = size_q;
  assign ARADDR         = addr_q;
  assign ARLEN          = len_q;
  assign ARSIZE         = size_q;
  assign WDATA          = wr_data;
  assign rd_data        = RDATA;
  assign done_resp      = resp_q;
  assign done_proto_err = perr_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      beat_cnt <= '0;
      resp_q   <= RESP_OKAY;
      perr_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            size_q <= cmd_size;
            if (reject) resp_q <= RESP_SLVERR;
          end
        end
        WR_DATA: begin
          if (w_hs) beat_cnt <= beat_cnt + 8'd1;
        end
        WR_RESP: begin
          if (BVALID) resp_q <= BRESP;
        end
        RD_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (RRESP > resp_q) resp_q <= RRESP;
            // RLAST must coincide exactly with the len-th beat.
            if (RLAST != last_beat) perr_q <= 1'b1;
          end
        end
        DONE: begin
          beat_cnt <= '0;
          resp_q   <= RESP_OKAY;
          perr_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    ARVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (reject)         state_nx = DONE;
          else if (cmd_write) state_nx = WR_ADDR;
          else                state_nx = RD_ADDR;
        end
      end
      WR_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nx = WR_DATA;
      end
      WR_DATA: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WLAST    = last_beat;
        if (w_hs && last_beat) state_nx = WR_RESP;
      end
      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) state_nx = DONE;
      end
      RD_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nx = RD_DATA;
      end
      RD_DATA: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_last  = RLAST;
        // A missing RLAST still closes the burst after len+1 beats.
        if (r_hs && (RLAST || last_beat)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Self-checking bench for axi4_burst_master with a behavioural AXI4 slave memory.
module tb_axi4_burst_master;
  import axi4_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
  logic          done, done_proto_err;
  logic [1:0]    done_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic          AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [1:0]    BRESP, RRESP;

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .done_proto_err(done_proto_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Slave model configuration and state
  int            aw_stall = 0;
  logic [1:0]    bresp_cfg = 2'b00;
  int            rlast_at = -1;
  logic [DW-1:0] mem [int];
  logic [32:0]   got_w [$];
  logic [32:0]   got_r [$];
  logic [32:0]   exp_w [$];
  logic [32:0]   exp_r [$];
  logic [DW-1:0] wq [$];
  logic [AW-1:0] aw_addr_seen;
  logic [7:0]    aw_len_seen;

  // Per-burst observations gathered by run_burst
  bit any_addr, aw_unstable, busy_ready;
  int aw_cycles;

  initial begin
    int scyc, aw_wait, w_base, w_idx, r_base, r_beat, r_len;
    bit b_pend, r_act;
    scyc = 0; aw_wait = 0; w_base = 0; w_idx = 0; r_base = 0; r_beat = 0; r_len = 0;
    b_pend = 0; r_act = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    forever begin
      @(negedge ACLK);
      scyc++;
      if (!ARESETn) begin
        aw_wait = 0; b_pend = 0; r_act = 0; w_idx = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
        continue;
      end
      AWREADY = AWVALID && (aw_wait >= aw_stall);
      WREADY  = (scyc % 3 != 2);
      BVALID  = b_pend;
      BRESP   = bresp_cfg;
      ARREADY = 1'b1;
      RVALID  = r_act && (scyc % 4 != 3);
      RDATA   = mem.exists(r_base + r_beat) ? mem[r_base + r_beat] : '0;
      RRESP   = 2'b00;
      RLAST   = r_act && (r_beat == ((rlast_at >= 0) ? rlast_at : r_len));
      #4;
      if (!ARESETn) continue;
      if (AWVALID && AWREADY) begin
        aw_addr_seen = AWADDR; aw_len_seen = AWLEN; aw_wait = 0;
        w_base = int'(AWADDR) >> 2; w_idx = 0;
      end else if (AWVALID) begin
        aw_wait++;
      end
      if (BVALID && BREADY) b_pend = 0;
      if (WVALID && WREADY) begin
        mem[w_base + w_idx] = WDATA;
        got_w.push_back({WLAST, WDATA});
        w_idx++;
        if (WLAST) b_pend = 1;
      end
      if (RVALID && RREADY) begin
        r_beat++;
        if (RLAST) r_act = 0;
      end
      if (ARVALID && ARREADY) begin
        r_act = 1; r_beat = 0; r_base = int'(ARADDR) >> 2; r_len = int'(ARLEN);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [7:0] l,
                       input logic [2:0] s, output bit ok);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge ACLK); #1;
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s;
      #3;
      if (cmd_ready) ok = 1;
    end
    @(posedge ACLK); #1;
    cmd_valid = 0;
  endtask

  task automatic run_burst(input int budget, input bit rd_toggle, output bit seen,
                           output logic [1:0] resp, output logic perr, output int lat);
    bit aw_first;
    logic [AW-1:0] a0;
    logic [7:0] l0;
    aw_first = 0; a0 = '0; l0 = '0;
    seen = 0; resp = '0; perr = 0; lat = -1;
    any_addr = 0; aw_unstable = 0; busy_ready = 0; aw_cycles = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge ACLK); #1;
      wr_valid = (wq.size() > 0);
      wr_data  = (wq.size() > 0) ? wq[0] : '0;
      rd_ready = rd_toggle ? ((c % 2) == 0) : 1'b1;
      #3;
      if (AWVALID || ARVALID) any_addr = 1;
      if (AWVALID) begin
        aw_cycles++;
        if (!aw_first) begin a0 = AWADDR; l0 = AWLEN; aw_first = 1; end
        else if (AWADDR !== a0 || AWLEN !== l0) aw_unstable = 1;
      end
      if (cmd_ready && (AWVALID || ARVALID || BREADY || RREADY || done)) busy_ready = 1;
      if (wr_valid && wr_ready) void'(wq.pop_front());
      if (rd_valid && rd_ready) got_r.push_back({rd_last, rd_data});
      if (done) begin seen = 1; resp = done_resp; perr = done_proto_err; lat = c; end
    end
    wr_valid = 0; rd_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge ACLK); @(negedge ACLK); #1;
    n_cmp++;
    if ({AWVALID, ARVALID, WVALID, BREADY, RREADY, done, rd_valid, wr_ready} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_valids got=%b want=00000000",
               {AWVALID, ARVALID, WVALID, BREADY, RREADY, done, rd_valid, wr_ready});
    end
    n_cmp++;
    if ({AWADDR, AWLEN, AWSIZE, done_resp} !== '0) begin
      n_err++; $display("FAIL reset_regs got addr=%h len=%h size=%h resp=%b want 0",
                        AWADDR, AWLEN, AWSIZE, done_resp);
    end
    ARESETn = 1;
    @(negedge ACLK); #4;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_idle cmd_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_write();
    bit ok, seen; logic [1:0] resp; logic perr; int lat;
    got_w.delete();
    for (int i = 0; i < 4; i++) begin
      wq.push_back(32'hA0 + i);
      exp_w.push_back({(i == 3), 32'hA0 + i});
    end
    issue(1, 16'h0010, 8'd3, 3'd2, ok);
    run_burst(100, 0, seen, resp, perr, lat);
    n_cmp++;
    if (!ok || !seen || resp !== RESP_OKAY || perr !== 1'b0) begin
      n_err++; $display("FAIL write_done ok=%0d seen=%0d resp=%b perr=%b want 1 1 00 0", ok, seen, resp, perr);
    end
    n_cmp++;
    if (aw_addr_seen !== 16'h0010 || aw_len_seen !== 8'd3 || busy_ready) begin
      n_err++; $display("FAIL write_aw addr=%h len=%0d busy_ready=%0d want 0010 3 0",
                        aw_addr_seen, aw_len_seen, busy_ready);
    end
    n_cmp++;
    if (got_w.size() != 4) begin n_err++; $display("FAIL write_count got=%0d want=4", got_w.size()); end
    while (exp_w.size() > 0 && got_w.size() > 0) begin
      logic [32:0] e, g;
      e = exp_w.pop_front(); g = got_w.pop_front();
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL write_beat got=%h want=%h", g, e); end
    end
    exp_w.delete();
    @(negedge ACLK); #4;
    n_cmp++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL done_pulse done=%b cmd_ready=%b want 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_read_toggle();
    bit ok, seen; logic [1:0] resp; logic perr; int lat;
    got_r.delete();
    for (int i = 0; i < 4; i++) exp_r.push_back({(i == 3), 32'hA0 + i});
    issue(0, 16'h0010, 8'd3, 3'd2, ok);
    run_burst(100, 1, seen, resp, perr, lat);
    n_cmp++;
    if (!ok || !seen || resp !== RESP_OKAY || perr !== 1'b0 || got_r.size() != 4) begin
      n_err++; $display("FAIL read_done seen=%0d resp=%b perr=%b beats=%0d want 1 00 0 4",
                        seen, resp, perr, got_r.size());
    end
    while (exp_r.size() > 0 && got_r.size() > 0) begin
      logic [32:0] e, g;
      e = exp_r.pop_front(); g = got_r.pop_front();
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL read_beat got=%h want=%h", g, e); end
    end
    exp_r.delete();
  endtask

  task automatic test_aw_stall_bresp();
    bit ok, seen; logic [1:0] resp; logic perr; int lat;
    aw_stall = 5; bresp_cfg = RESP_SLVERR; got_w.delete();
    wq.push_back(32'hB0); wq.push_back(32'hB1);
    issue(1, 16'h0020, 8'd1, 3'd2, ok);
    run_burst(100, 0, seen, resp, perr, lat);
    n_cmp++;
    if (aw_unstable || aw_cycles != 6) begin
      n_err++; $display("FAIL aw_stall unstable=%0d aw_cycles=%0d want 0 6", aw_unstable, aw_cycles);
    end
    n_cmp++;
    if (!seen || resp !== RESP_SLVERR || got_w.size() != 2) begin
      n_err++; $display("FAIL bresp_err seen=%0d resp=%b beats=%0d want 1 10 2", seen, resp, got_w.size());
    end
    aw_stall = 0; bresp_cfg = RESP_OKAY;
  endtask

  task automatic test_rlast_early();
    bit ok, seen; logic [1:0] resp; logic perr; int lat;
    rlast_at = 1; got_r.delete();
    issue(0, 16'h0010, 8'd3, 3'd2, ok);
    run_burst(100, 0, seen, resp, perr, lat);
    n_cmp++;
    if (!seen || perr !== 1'b1 || resp !== RESP_OKAY) begin
      n_err++; $display("FAIL rlast_early seen=%0d perr=%b resp=%b want 1 1 00", seen, perr, resp);
    end
    n_cmp++;
    if (got_r.size() != 2 || got_r[1] !== {1'b1, 32'hA1}) begin
      n_err++; $display("FAIL rlast_beats count=%0d want=2 (last A1)", got_r.size());
    end
    rlast_at = -1;
  endtask

  task automatic test_illegal_size();
    bit ok, seen; logic [1:0] resp; logic perr; int lat;
    issue(1, 16'h0030, 8'd0, 3'd3, ok);
    run_burst(20, 0, seen, resp, perr, lat);
    n_cmp++;
    if (!seen || any_addr || resp !== RESP_SLVERR || lat > 1) begin
      n_err++; $display("FAIL bad_size seen=%0d addr_traffic=%0d resp=%b lat=%0d want 1 0 10 <=1",
                        seen, any_addr, resp, lat);
    end
  endtask

  task automatic test_boundary();
    bit ok, seen; logic [1:0] resp; logic perr; int lat;
`ifdef AXI4_BOUNDARY_CHECK_EN
    issue(1, 16'h0FF0, 8'd7, 3'd2, ok);
    run_burst(20, 0, seen, resp, perr, lat);
    n_cmp++;
    if (!seen || any_addr || resp !== RESP_SLVERR) begin
      n_err++; $display("FAIL cross_4k seen=%0d addr_traffic=%0d resp=%b want 1 0 10", seen, any_addr, resp);
    end
    got_w.delete();
    for (int i = 0; i < 8; i++) wq.push_back(32'hC0 + i);
    issue(1, 16'h0FE0, 8'd7, 3'd2, ok);
`else
    got_w.delete();
    for (int i = 0; i < 8; i++) wq.push_back(32'hC0 + i);
    issue(1, 16'h0FF0, 8'd7, 3'd2, ok);
`endif
    run_burst(200, 0, seen, resp, perr, lat);
    n_cmp++;
    if (!seen || !any_addr || resp !== RESP_OKAY || got_w.size() != 8) begin
      n_err++; $display("FAIL in_4k seen=%0d addr_traffic=%0d resp=%b beats=%0d want 1 1 00 8",
                        seen, any_addr, resp, got_w.size());
    end
  endtask

  task automatic test_len_edges();
    bit ok, seen; logic [1:0] resp; logic perr; int lat;
    got_w.delete(); got_r.delete();
    wq.push_back(32'h55);
    issue(1, 16'h0040, 8'd0, 3'd2, ok);
    run_burst(50, 0, seen, resp, perr, lat);
    n_cmp++;
    if (!seen || got_w.size() != 1 || got_w[0] !== {1'b1, 32'h55}) begin
      n_err++; $display("FAIL len0_write seen=%0d beats=%0d want 1 1 (last 55)", seen, got_w.size());
    end
    exp_r.push_back({1'b1, 32'h55});
    issue(0, 16'h0040, 8'd0, 3'd2, ok);
    run_burst(50, 0, seen, resp, perr, lat);
    while (exp_r.size() > 0) begin
      logic [32:0] e, g;
      e = exp_r.pop_front(); g = (got_r.size() > 0) ? got_r.pop_front() : 'x;
      n_cmp++;
      if (g !== e || perr !== 1'b0) begin n_err++; $display("FAIL len0_read got=%h perr=%b want=%h 0", g, perr, e); end
    end
    got_w.delete();
    for (int i = 0; i < 256; i++) begin
      wq.push_back(32'h1000 + i);
      exp_w.push_back({(i == 255), 32'h1000 + i});
    end
    issue(1, 16'h1000, 8'd255, 3'd2, ok);
    run_burst(1200, 0, seen, resp, perr, lat);
    n_cmp++;
    if (!seen || resp !== RESP_OKAY || got_w.size() != 256) begin
      n_err++; $display("FAIL len255 seen=%0d resp=%b beats=%0d want 1 00 256", seen, resp, got_w.size());
    end
    while (exp_w.size() > 0 && got_w.size() > 0) begin
      logic [32:0] e, g;
      e = exp_w.pop_front(); g = got_w.pop_front();
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL len255_beat got=%h want=%h", g, e); end
    end
    exp_w.delete();
  endtask

  task automatic test_reset_mid_burst();
    bit ok, seen; logic [1:0] resp; logic perr; int lat;
    for (int i = 0; i < 8; i++) wq.push_back(32'hD0 + i);
    issue(1, 16'h0080, 8'd7, 3'd2, ok);
    run_burst(6, 0, seen, resp, perr, lat);
    @(negedge ACLK); #1;
    wr_valid = 1; ARESETn = 0;
    #1;
    n_cmp++;
    if ({AWVALID, ARVALID, WVALID, BREADY, RREADY, done} !== 6'b0 || seen) begin
      n_err++; $display("FAIL reset_mid valids=%b seen=%0d want 000000 0",
                        {AWVALID, ARVALID, WVALID, BREADY, RREADY, done}, seen);
    end
    wr_valid = 0; wq.delete();
    @(negedge ACLK); @(negedge ACLK); #1;
    ARESETn = 1;
    run_burst(5, 0, seen, resp, perr, lat);
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL reset_no_done seen=%0d want=0", seen); end
    got_r.delete();
    issue(0, 16'h0010, 8'd0, 3'd2, ok);
    run_burst(50, 0, seen, resp, perr, lat);
    n_cmp++;
    if (!ok || !seen || got_r.size() != 1 || got_r[0] !== {1'b1, 32'hA0}) begin
      n_err++; $display("FAIL reset_recover ok=%0d seen=%0d beats=%0d want 1 1 1 (A0)", ok, seen, got_r.size());
    end
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    test_reset();
    test_write();
    test_read_toggle();
    test_aw_stall_bresp();
    test_rlast_early();
    test_illegal_size();
    test_boundary();
    test_len_edges();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
